// File: rtl/watchdog_sequencer_if.sv
// Watchdog register bus: sequencer (master) to watchdog core wrapper (slave).
interface watchdog_sequencer_if;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              wd_cs;
    logic              wd_we;
    logic [ADDR_W-1:0] wd_address;
    logic [DATA_W-1:0] wd_write_data;
    logic [DATA_W-1:0] wd_read_data;
    logic              wd_ready;

    modport master (
        output wd_cs, wd_we, wd_address, wd_write_data,
        input  wd_read_data, wd_ready
    );

    modport slave (
        input  wd_cs, wd_we, wd_address, wd_write_data,
        output wd_read_data, wd_ready
    );
endinterface

// File: rtl/watchdog_sequencer.sv
// Programs and services the watchdog over its register bus on behalf of hardware agents:
// configure (prescaler + timeout, verified), kick (stop/start) and halt.
module watchdog_sequencer #(
    parameter logic [7:0]  ADDR_CTRL      = 8'h08,
    parameter logic [7:0]  ADDR_STATUS    = 8'h09,
    parameter logic [7:0]  ADDR_PRESCALER = 8'h0a,
    parameter logic [7:0]  ADDR_WATCHDOG  = 8'h0b,
    parameter int unsigned POLL_MAX       = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_req,
    input  logic [31:0]          cfg_prescaler,
    input  logic [31:0]          cfg_timeout,
    input  logic                 kick_req,
    input  logic                 halt_req,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    watchdog_sequencer_if.master wd
);
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_STAT,
        S_WR_STOP,
        S_POLL_STOP,
        S_WR_PRE,
        S_WR_WDG,
        S_RD_PRE,
        S_RD_WDG,
        S_WR_START,
        S_POLL_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_HALT,
        OP_CFG,
        OP_KICK
    } op_t;

    state_t             state, state_nxt, stopped_nxt;
    op_t                op, op_nxt;
    logic               busy_nxt, done_nxt, error_nxt;
    logic               cs_nxt, we_nxt;
    logic [ADDR_W-1:0]  addr_nxt, acc_addr;
    logic [DATA_W-1:0]  wdata_nxt, acc_data;
    logic               acc_we;
    logic [DATA_W-1:0]  pre_q, pre_nxt, tmo_q, tmo_nxt;
    logic [CNT_W-1:0]   poll_cnt, cnt_nxt;
    logic               access_done, rd_ready, is_access, poll_last, accept;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            op               <= OP_HALT;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            wd.wd_cs         <= 1'b0;
            wd.wd_we         <= 1'b0;
            wd.wd_address    <= '0;
            wd.wd_write_data <= '0;
            pre_q            <= '0;
            tmo_q            <= '0;
            poll_cnt         <= '0;
        end else begin
            state            <= state_nxt;
            op               <= op_nxt;
            busy             <= busy_nxt;
            done             <= done_nxt;
            error            <= error_nxt;
            wd.wd_cs         <= cs_nxt;
            wd.wd_we         <= we_nxt;
            wd.wd_address    <= addr_nxt;
            wd.wd_write_data <= wdata_nxt;
            pre_q            <= pre_nxt;
            tmo_q            <= tmo_nxt;
            poll_cnt         <= cnt_nxt;
        end
    end

    // Next-state, bus access and output logic
    always_comb begin
        state_nxt   = state;
        op_nxt      = op;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        error_nxt   = error;
        cs_nxt      = wd.wd_cs;
        we_nxt      = wd.wd_we;
        addr_nxt    = wd.wd_address;
        wdata_nxt   = wd.wd_write_data;
        pre_nxt     = pre_q;
        tmo_nxt     = tmo_q;
        cnt_nxt     = poll_cnt;
        acc_we      = 1'b0;
        acc_addr    = ADDR_STATUS;
        acc_data    = '0;
        accept      = 1'b0;
        access_done = wd.wd_cs && wd.wd_ready;
        rd_ready    = wd.wd_read_data[0];
        poll_last   = (poll_cnt == CNT_W'(POLL_MAX - 1));
        is_access   = (state != S_IDLE) && (state != S_DONE);

        // Where to continue once the watchdog is known to be stopped
        case (op)
            OP_CFG:  stopped_nxt = S_WR_PRE;
            OP_KICK: stopped_nxt = S_WR_START;
            default: stopped_nxt = S_DONE;
        endcase

        case (state)
            S_WR_STOP, S_WR_START: begin
                acc_we   = 1'b1;
                acc_addr = ADDR_CTRL;
                acc_data = DATA_W'(1);
            end
            S_WR_PRE: begin
                acc_we   = 1'b1;
                acc_addr = ADDR_PRESCALER;
                acc_data = pre_q;
            end
            S_WR_WDG: begin
                acc_we   = 1'b1;
                acc_addr = ADDR_WATCHDOG;
                acc_data = tmo_q;
            end
            S_RD_PRE: acc_addr = ADDR_PRESCALER;
            S_RD_WDG: acc_addr = ADDR_WATCHDOG;
            default:  ;
        endcase

        // Each access state enters with cs low, which also gives the idle gap
        if (is_access && !wd.wd_cs) begin
            cs_nxt    = 1'b1;
            we_nxt    = acc_we;
            addr_nxt  = acc_addr;
            wdata_nxt = acc_data;
        end else if (access_done) begin
            cs_nxt = 1'b0;
            we_nxt = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (halt_req) begin
                    op_nxt = OP_HALT;
                    accept = 1'b1;
                end else if (cfg_req) begin
                    op_nxt  = OP_CFG;
                    pre_nxt = cfg_prescaler;
                    tmo_nxt = cfg_timeout;
                    accept  = 1'b1;
                end else if (kick_req) begin
                    op_nxt = OP_KICK;
                    accept = 1'b1;
                end
                if (accept) begin
                    busy_nxt  = 1'b1;
                    error_nxt = 1'b0;
                    state_nxt = S_RD_STAT;
                end
            end
            S_RD_STAT: if (access_done) state_nxt = rd_ready ? stopped_nxt : S_WR_STOP;
            S_WR_STOP: if (access_done) begin
                state_nxt = S_POLL_STOP;
                cnt_nxt   = '0;
            end
            S_POLL_STOP: if (access_done) begin
                if (rd_ready) begin
                    state_nxt = stopped_nxt;
                end else if (poll_last) begin
                    error_nxt = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = poll_cnt + CNT_W'(1);
                end
            end
            S_WR_PRE: if (access_done) state_nxt = S_WR_WDG;
            S_WR_WDG: if (access_done) state_nxt = S_RD_PRE;
            S_RD_PRE: if (access_done) begin
                if (wd.wd_read_data == pre_q) begin
                    state_nxt = S_RD_WDG;
                end else begin
                    error_nxt = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_RD_WDG: if (access_done) begin
                if (wd.wd_read_data == tmo_q) begin
                    state_nxt = S_WR_START;
                end else begin
                    error_nxt = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_WR_START: if (access_done) begin
                state_nxt = S_POLL_RUN;
                cnt_nxt   = '0;
            end
            S_POLL_RUN: if (access_done) begin
                if (!rd_ready) begin
                    state_nxt = S_DONE;
                end else if (poll_last) begin
                    error_nxt = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = poll_cnt + CNT_W'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // done pulses (and busy drops) in the single cycle spent in DONE
        if ((state_nxt == S_DONE) && (state != S_DONE)) begin
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
        end
    end
endmodule

// File: tb/tb_watchdog_sequencer.sv
// Randomised bench for watchdog_sequencer: watchdog slave model plus a sequence-level reference model.
module tb_watchdog_sequencer;
    localparam int        POLL_MAX = 8;
    localparam logic [7:0] A_CTRL = 8'h08, A_STAT = 8'h09, A_PRE = 8'h0a, A_WDG = 8'h0b;
    localparam int        OP_HALT = 0, OP_CFG = 1, OP_KICK = 2;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_req = 1'b0, kick_req = 1'b0, halt_req = 1'b0;
    logic [31:0] cfg_prescaler = '0, cfg_timeout = '0;
    logic        busy, done, error;

    watchdog_sequencer_if wd_bus ();

    watchdog_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_req       (cfg_req),
        .cfg_prescaler (cfg_prescaler),
        .cfg_timeout   (cfg_timeout),
        .kick_req      (kick_req),
        .halt_req      (halt_req),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .wd            (wd_bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Watchdog slave environment
    bit          sl_running = 0, sl_stuck = 0, sl_corrupt = 0;
    int          sl_lag_cfg = 0, sl_lag = 0, sl_dly_max = 0, sl_dly_cur = 0, sl_dly_cnt = 0;
    logic [31:0] sl_pre = '0, sl_wdg = '0;
    acc_t        log_q[$];

    // Reference model state
    acc_t exp_q[$];
    bit   exp_err;
    bit   mdl_running = 0;

    initial begin
        acc_t e;
        wd_bus.wd_ready     = 1'b0;
        wd_bus.wd_read_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                wd_bus.wd_ready = 1'b0;
                sl_dly_cnt      = 0;
            end else if (wd_bus.wd_ready) begin
                wd_bus.wd_ready = 1'b0;
            end else if (wd_bus.wd_cs) begin
                if (sl_dly_cnt < sl_dly_cur) begin
                    sl_dly_cnt++;
                end else begin
                    e.we   = wd_bus.wd_we;
                    e.addr = wd_bus.wd_address;
                    e.data = wd_bus.wd_we ? wd_bus.wd_write_data : 32'h0;
                    log_q.push_back(e);
                    wd_bus.wd_read_data = '0;
                    if (e.we) begin
                        case (e.addr)
                            A_CTRL: begin sl_running = !sl_running; sl_lag = sl_lag_cfg; end
                            A_PRE:  sl_pre = e.data;
                            A_WDG:  sl_wdg = e.data;
                            default: ;
                        endcase
                    end else begin
                        case (e.addr)
                            A_STAT: begin
                                if (sl_stuck) wd_bus.wd_read_data = 32'h0;
                                else if (sl_lag > 0) begin
                                    sl_lag--;
                                    wd_bus.wd_read_data = {31'h0, sl_running};
                                end else wd_bus.wd_read_data = {31'h0, !sl_running};
                            end
                            A_PRE:   wd_bus.wd_read_data = sl_pre;
                            A_WDG:   wd_bus.wd_read_data = sl_corrupt ? sl_wdg - 32'h1 : sl_wdg;
                            default: ;
                        endcase
                    end
                    wd_bus.wd_ready = 1'b1;
                    sl_dly_cnt = 0;
                    sl_dly_cur = $urandom_range(sl_dly_max);
                end
            end
        end
    end

    function automatic acc_t mk(input bit we, input logic [7:0] a, input logic [31:0] d);
        acc_t r;
        r.we = we; r.addr = a; r.data = d;
        return r;
    endfunction

    // Expected bus trace and error from the request rules and the watchdog's status behaviour
    task automatic build_expected(input int op, input logic [31:0] p, input logic [31:0] t,
                                  input int lag, input bit stuck, input bit corrupt);
        int n;
        exp_q.delete();
        exp_err = 0;
        exp_q.push_back(mk(0, A_STAT, 0));
        if (mdl_running || stuck) begin
            exp_q.push_back(mk(1, A_CTRL, 1));
            mdl_running = !mdl_running;
            n = stuck ? POLL_MAX : ((lag + 1 > POLL_MAX) ? POLL_MAX : lag + 1);
            repeat (n) exp_q.push_back(mk(0, A_STAT, 0));
            if (stuck || lag + 1 > POLL_MAX) begin exp_err = 1; return; end
        end
        if (op == OP_HALT) return;
        if (op == OP_CFG) begin
            exp_q.push_back(mk(1, A_PRE, p));
            exp_q.push_back(mk(1, A_WDG, t));
            exp_q.push_back(mk(0, A_PRE, 0));
            exp_q.push_back(mk(0, A_WDG, 0));
            if (corrupt) begin exp_err = 1; return; end
        end
        exp_q.push_back(mk(1, A_CTRL, 1));
        mdl_running = 1;
        n = (lag + 1 > POLL_MAX) ? POLL_MAX : lag + 1;
        repeat (n) exp_q.push_back(mk(0, A_STAT, 0));
        if (lag + 1 > POLL_MAX) exp_err = 1;
    endtask

    function automatic int trace_diff();
        int n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (log_q[i] !== exp_q[i]) return i;
        if (log_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Issue one request and wait (bounded) for done; optionally pulse kick_req while busy
    task automatic run_req(input bit h, input bit c, input bit k, input logic [31:0] p,
                           input logic [31:0] t, input int kick_at, output int cycles,
                           output bit timeout, output bit busy_seen, output bit err_accept);
        @(negedge clk);
        log_q.delete();
        halt_req = h; cfg_req = c; kick_req = k; cfg_prescaler = p; cfg_timeout = t;
        @(negedge clk);
        halt_req = 0; cfg_req = 0; kick_req = 0;
        cycles = 1; timeout = 0; busy_seen = busy; err_accept = error;
        forever begin
            if (done) break;
            if (cycles >= 3000) begin timeout = 1; break; end
            kick_req = (cycles == kick_at);
            @(negedge clk);
            cycles++;
        end
        kick_req = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(negedge clk);
        n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: busy/done/error=%b required 000", {busy, done, error}); end
        n_checks++; if ({wd_bus.wd_cs, wd_bus.wd_we} !== 2'b00) begin n_fail++; $display("FAIL reset_bus_ctl: cs/we=%b required 00", {wd_bus.wd_cs, wd_bus.wd_we}); end
        n_checks++; if ({wd_bus.wd_address, wd_bus.wd_write_data} !== 40'h0) begin n_fail++; $display("FAIL reset_bus_data: addr=%h data=%h required 0", wd_bus.wd_address, wd_bus.wd_write_data); end
        reset_n = 1;
        repeat (3) @(negedge clk);
        n_checks++; if ({busy, wd_bus.wd_cs} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: busy/cs=%b required 00 with no request", {busy, wd_bus.wd_cs}); end
    endtask

    task automatic test_cfg_stopped();
        int cyc, d; bit to, bs, ea;
        sl_running = 0; mdl_running = 0; sl_lag_cfg = 0; sl_dly_max = 0; sl_dly_cur = 0;
        build_expected(OP_CFG, 32'h0000_0064, 32'h0000_1000, 0, 0, 0);
        run_req(0, 1, 0, 32'h0000_0064, 32'h0000_1000, -1, cyc, to, bs, ea);
        n_checks++; if (to) begin n_fail++; $display("FAIL cfg_timeout: no done within %0d cycles", cyc); end
        n_checks++; if (!bs) begin n_fail++; $display("FAIL cfg_busy: busy=%b after accept required 1", bs); end
        n_checks++; if (cyc != 15) begin n_fail++; $display("FAIL cfg_latency: done %0d edges after request required 15 (16 cycles incl. request)", cyc); end
        d = trace_diff();
        n_checks++; if (d >= 0) begin n_fail++; $display("FAIL cfg_trace: entry %0d got %h required %h (%0d/%0d accesses)", d, log_q[d], exp_q[d], log_q.size(), exp_q.size()); end
        n_checks++; if ({error, busy} !== {exp_err, 1'b0}) begin n_fail++; $display("FAIL cfg_done_flags: error/busy=%b required %b0", {error, busy}, exp_err); end
        n_checks++; if (sl_running != mdl_running) begin n_fail++; $display("FAIL cfg_running: watchdog running=%b required %b", sl_running, mdl_running); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cfg_done_pulse: done=%b one cycle later required 0", done); end
    endtask

    task automatic test_kick_running();
        int cyc, d; bit to, bs, ea;
        sl_lag_cfg = 2;
        build_expected(OP_KICK, 0, 0, 2, 0, 0);
        run_req(0, 0, 1, 32'hdead_beef, 32'h1234_5678, -1, cyc, to, bs, ea);
        n_checks++; if (to) begin n_fail++; $display("FAIL kick_timeout: no done within %0d cycles", cyc); end
        d = trace_diff();
        n_checks++; if (d >= 0) begin n_fail++; $display("FAIL kick_trace: entry %0d got %h required %h (%0d/%0d accesses)", d, log_q[d], exp_q[d], log_q.size(), exp_q.size()); end
        n_checks++; if (cyc != 2 * exp_q.size() + 1) begin n_fail++; $display("FAIL kick_latency: %0d edges required %0d", cyc, 2 * exp_q.size() + 1); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL kick_error: error=%b required 0", error); end
    endtask

    task automatic test_priority();
        int cyc, d, sz; bit to, bs, ea;
        sl_lag_cfg = 0;
        build_expected(OP_HALT, 0, 0, 0, 0, 0);
        run_req(1, 1, 1, 32'h1111_1111, 32'h2222_2222, 4, cyc, to, bs, ea);
        n_checks++; if (to) begin n_fail++; $display("FAIL prio_timeout: no done within %0d cycles", cyc); end
        d = trace_diff();
        n_checks++; if (d >= 0) begin n_fail++; $display("FAIL prio_trace: entry %0d got %h required %h (%0d/%0d accesses)", d, log_q[d], exp_q[d], log_q.size(), exp_q.size()); end
        sz = log_q.size();
        repeat (8) @(negedge clk);
        n_checks++; if (log_q.size() != sz || busy !== 1'b0) begin n_fail++; $display("FAIL prio_ignored: %0d accesses busy=%b after done required %0d, 0", log_q.size(), busy, sz); end
        n_checks++; if (sl_running != mdl_running) begin n_fail++; $display("FAIL prio_running: running=%b required %b", sl_running, mdl_running); end
    endtask

    task automatic test_verify_error();
        int cyc, d; bit to, bs, ea;
        sl_corrupt = 1;
        build_expected(OP_CFG, 32'h0000_0064, 32'h0000_1000, 0, 0, 1);
        run_req(0, 1, 0, 32'h0000_0064, 32'h0000_1000, -1, cyc, to, bs, ea);
        sl_corrupt = 0;
        n_checks++; if (to) begin n_fail++; $display("FAIL verify_timeout: no done within %0d cycles", cyc); end
        d = trace_diff();
        n_checks++; if (d >= 0) begin n_fail++; $display("FAIL verify_trace: entry %0d got %h required %h (%0d/%0d accesses)", d, log_q[d], exp_q[d], log_q.size(), exp_q.size()); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL verify_error: error=%b required 1", error); end
        n_checks++; if (sl_running !== 1'b0) begin n_fail++; $display("FAIL verify_stopped: running=%b required 0", sl_running); end
        build_expected(OP_HALT, 0, 0, 0, 0, 0);
        run_req(1, 0, 0, 0, 0, -1, cyc, to, bs, ea);
        n_checks++; if (ea !== 1'b0) begin n_fail++; $display("FAIL verify_clear: error=%b after halt accept required 0", ea); end
        d = trace_diff();
        n_checks++; if (d >= 0 || error !== 1'b0) begin n_fail++; $display("FAIL verify_halt: trace diff %0d error=%b required -1, 0", d, error); end
    endtask

    task automatic test_poll_overflow();
        int cyc, d, nstat; bit to, bs, ea;
        sl_running = 1; mdl_running = 1; sl_stuck = 1;
        build_expected(OP_HALT, 0, 0, 0, 1, 0);
        run_req(1, 0, 0, 0, 0, -1, cyc, to, bs, ea);
        sl_stuck = 0;
        n_checks++; if (to) begin n_fail++; $display("FAIL poll_timeout: no done within %0d cycles", cyc); end
        nstat = 0;
        for (int i = 2; i < log_q.size(); i++) if (!log_q[i].we && log_q[i].addr == A_STAT) nstat++;
        n_checks++; if (nstat != POLL_MAX) begin n_fail++; $display("FAIL poll_count: %0d STATUS polls required %0d", nstat, POLL_MAX); end
        d = trace_diff();
        n_checks++; if (d >= 0) begin n_fail++; $display("FAIL poll_trace: entry %0d got %h required %h (%0d/%0d accesses)", d, log_q[d], exp_q[d], log_q.size(), exp_q.size()); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL poll_error: error=%b required 1", error); end
    endtask

    task automatic test_reset_mid();
        int cyc, d; bit to, bs, ea, found;
        sl_running = 0; mdl_running = 0; sl_lag_cfg = 0; sl_dly_max = 0;
        @(negedge clk);
        cfg_req = 1; cfg_prescaler = 32'h55; cfg_timeout = 32'h777;
        @(negedge clk);
        cfg_req = 0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (wd_bus.wd_cs && wd_bus.wd_address == A_WDG) found = 1;
            else @(negedge clk);
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_reach: WATCHDOG write not seen, found=%b required 1", found); end
        #2 reset_n = 0;
        #1;
        n_checks++; if ({wd_bus.wd_cs, wd_bus.wd_we, busy, error, done} !== 5'b0) begin n_fail++; $display("FAIL rstmid_async: cs/we/busy/error/done=%b required 00000", {wd_bus.wd_cs, wd_bus.wd_we, busy, error, done}); end
        n_checks++; if ({wd_bus.wd_address, wd_bus.wd_write_data} !== 40'h0) begin n_fail++; $display("FAIL rstmid_bus: addr=%h data=%h required 0", wd_bus.wd_address, wd_bus.wd_write_data); end
        repeat (2) @(negedge clk);
        reset_n = 1;
        build_expected(OP_CFG, 32'hcafe_0001, 32'h0000_2000, 0, 0, 0);
        run_req(0, 1, 0, 32'hcafe_0001, 32'h0000_2000, -1, cyc, to, bs, ea);
        d = trace_diff();
        n_checks++; if (to || d >= 0) begin n_fail++; $display("FAIL rstmid_after: timeout=%b trace diff %0d required 0, -1", to, d); end
        n_checks++; if (cyc != 15 || error !== 1'b0) begin n_fail++; $display("FAIL rstmid_latency: %0d edges error=%b required 15, 0", cyc, error); end
    endtask

    task automatic test_random();
        int cyc, d, lag, op; bit to, bs, ea, h, c, k, corrupt;
        logic [31:0] p, t;
        for (int it = 0; it < 24; it++) begin
            do begin
                h = 1'($urandom_range(1)); c = 1'($urandom_range(1)); k = 1'($urandom_range(1));
            end while (!(h || c || k));
            p = $urandom; t = $urandom;
            lag = $urandom_range(3);
            corrupt = ($urandom_range(5) == 0);
            sl_lag_cfg = lag; sl_dly_max = $urandom_range(2); sl_corrupt = corrupt;
            op = h ? OP_HALT : (c ? OP_CFG : OP_KICK);
            build_expected(op, p, t, lag, 0, corrupt);
            run_req(h, c, k, p, t, -1, cyc, to, bs, ea);
            d = trace_diff();
            n_checks++; if (to || d >= 0) begin n_fail++; $display("FAIL rand_trace[%0d] op %0d: timeout=%b entry %0d got %h required %h", it, op, to, d, log_q[d], exp_q[d]); end
            n_checks++; if (error !== exp_err || sl_running != mdl_running) begin n_fail++; $display("FAIL rand_result[%0d] op %0d: error=%b running=%b required %b %b", it, op, error, sl_running, exp_err, mdl_running); end
        end
        sl_corrupt = 0; sl_dly_max = 0;
    endtask

    initial begin
        test_reset();
        test_cfg_stopped();
        test_kick_running();
        test_priority();
        test_verify_error();
        test_poll_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/watchdog_sequencer.md
Name: watchdog_sequencer

Overview:
- Bus-master controller that programs and services the watchdog through its 8-bit-address register interface, so hardware agents never touch the watchdog bus directly.
- Accepts three request types: configure (prescaler and timeout), kick (restart the countdown) and halt.
- Issues the required CTRL/STATUS/PRESCALER/WATCHDOG accesses in order and verifies the result.
- Sits between the security-monitor logic and the watchdog core wrapper.

Parameters:
ADDR_CTRL, 8'h08, start/stop toggle register address
ADDR_STATUS, 8'h09, status address; bit0 = ready (1 = stopped/idle)
ADDR_PRESCALER, 8'h0a, prescaler init register address
ADDR_WATCHDOG, 8'h0b, watchdog init register address
POLL_MAX, 8, max STATUS reads waiting for a state change before error

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_req  in  1  pulse: reprogram with cfg_prescaler/cfg_timeout, then start
cfg_prescaler  in  32  prescaler value, sampled on accepted cfg_req
cfg_timeout  in  32  watchdog init value, sampled on accepted cfg_req
kick_req  in  1  pulse: restart countdown with current init values
halt_req  in  1  pulse: stop watchdog
busy  out  1  sequence in progress; requests ignored while high
done  out  1  one-cycle pulse at sequence end
error  out  1  sticky; set on verify mismatch or poll overflow; cleared by next accepted request
wd_cs  out  1  watchdog bus chip select
wd_we  out  1  watchdog bus write enable
wd_address  out  8  watchdog bus address
wd_write_data  out  32  watchdog bus write data
wd_read_data  in  32  watchdog bus read data, valid while wd_ready
wd_ready  in  1  watchdog bus access complete

Behaviour:
- Reset (async, active-low): state IDLE. busy, done, error, wd_cs and wd_we = 0; wd_address = 0; wd_write_data = 0; latched config = 0.
- Bus access:
  - wd_cs/wd_we/wd_address/wd_write_data are registered and held until a cycle with wd_ready = 1.
  - Read data is captured in that cycle.
  - wd_cs drops the following cycle; minimum one idle cycle between accesses.
- Arbitration in IDLE: priority halt > cfg > kick.
  - The accepted request sets busy the next cycle and clears error.
  - Lower-priority requests in the same cycle are dropped.
  - Requests while busy are ignored, not queued.
- Common prologue for all requests: RD_STAT reads STATUS.
- halt:
  - ready = 1 -> DONE.
  - ready = 0 -> WR_CTRL (write 1 to CTRL) -> POLL_STOP (read STATUS until ready = 1) -> DONE.
- cfg:
  - If ready = 0, stop first via WR_CTRL/POLL_STOP.
  - Then WR_PRE (prescaler) -> WR_WDG (timeout) -> RD_PRE and RD_WDG (readback compare against latched values) -> WR_CTRL (start) -> POLL_RUN (read STATUS until ready = 0) -> DONE.
- kick:
  - If running, stop via WR_CTRL/POLL_STOP.
  - Then WR_CTRL (start) -> POLL_RUN -> DONE. Init registers are untouched.
  - If already stopped, kick starts the watchdog.
- Verify mismatch: set error, skip start, go to DONE. The watchdog is left stopped.
- POLL_* counts reads.
  - On reading POLL_MAX times without the expected value: set error -> DONE.
  - The counter resets on entering each POLL state.
- DONE: done = 1 for exactly one cycle, busy = 0 the same cycle, return to IDLE.
  - A new request may be accepted the cycle after done.
- reset_n asserted mid-sequence: immediate return to reset values, even with wd_cs high.
- Latency with 1-cycle wd_ready, counting each access as 2 cycles:
  - cfg from the stopped state: accept + 7 accesses + DONE = 16 cycles from request to done pulse.

Test Plan:
1. Stopped watchdog; cfg_req with prescaler 32'h0000_0064, timeout 32'h0000_1000 -> bus sequence STATUS(rd) → 0a←0x64 → 0b←0x1000 → 0a rd → 0b rd → 08←1 → STATUS rd = 0; done after 16 cycles; error = 0.
2. Running watchdog; kick_req -> STATUS rd → 08 write → STATUS rd until ready = 1 → 08 write → STATUS rd until ready = 0; no writes to 0a/0b; done pulse.
3. Same-cycle halt_req, cfg_req and kick_req in IDLE -> only the halt sequence runs; a further kick_req while busy is ignored (no extra bus traffic).
4. Readback of 0b returns 32'h0000_0FFF instead of 32'h1000 -> error = 1, no CTRL start write, done pulse; a following halt_req clears error.
5. STATUS stuck at ready = 0 during POLL_STOP -> exactly 8 STATUS reads, then error = 1 and done.
6. reset_n low during WR_WDG with wd_cs high -> wd_cs = 0, busy = 0 and error = 0 asynchronously; a request after release starts from IDLE.
